// File: rtl/logic16_acc_if.sv
// Stream interface for logic16_acc: input beat (operands, op, accumulate control)
// and registered result with status flags and beat counter.
interface logic16_acc_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             acc_en;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zr;
  logic             ng;
  logic             all1;
  logic [CNT_W-1:0] beats;

  modport master (
    output in_valid, a, b, op, acc_en, acc_clr, out_ready,
    input  in_ready, out_valid, out, zr, ng, all1, beats
  );

  modport slave (
    input  in_valid, a, b, op, acc_en, acc_clr, out_ready,
    output in_ready, out_valid, out, zr, ng, all1, beats
  );
endinterface

// File: rtl/logic16_acc.sv
// Registered bitwise logic unit with a one-deep output register and an internal
// accumulator for running OR/AND/XOR reductions across successive beats.
module logic16_acc #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input logic          clk,
  input logic          reset,
  logic16_acc_if.slave bus
);

  typedef enum logic [2:0] {
    OpAnd   = 3'b000,
    OpOr    = 3'b001,
    OpXor   = 3'b010,
    OpNand  = 3'b011,
    OpNor   = 3'b100,
    OpXnor  = 3'b101,
    OpNotA  = 3'b110,
    OpPassA = 3'b111
  } op_e;

  function automatic logic [WIDTH-1:0] apply_op(input op_e op, input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    unique case (op)
      OpAnd:   r = x & y;
      OpOr:    r = x | y;
      OpXor:   r = x ^ y;
      OpNand:  r = ~(x & y);
      OpNor:   r = ~(x | y);
      OpXnor:  r = ~(x ^ y);
      OpNotA:  r = ~x;
      OpPassA: r = x;
      default: r = x;
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic             out_valid_q, out_valid_d;
  logic             zr_q, zr_d;
  logic             ng_q, ng_d;
  logic             all1_q, all1_d;
  logic             in_ready;
  logic             accept;
  logic [WIDTH-1:0] result;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    result      = '0;
    out_d       = out_q;
    acc_d       = acc_q;
    beats_d     = beats_q;
    out_valid_d = out_valid_q;
    zr_d        = zr_q;
    ng_d        = ng_q;
    all1_d      = all1_q;

    if (accept) begin
      if (bus.acc_clr) begin
        result  = bus.a;
        acc_d   = bus.a;
        beats_d = CNT_W'(1);
      end else if (bus.acc_en) begin
        result = apply_op(op_e'(bus.op), acc_q, bus.a);
        acc_d  = result;
        // Saturate rather than wrap so a long reduction never looks freshly cleared.
        if (beats_q != '1) begin
          beats_d = beats_q + CNT_W'(1);
        end
      end else begin
        result = apply_op(op_e'(bus.op), bus.a, bus.b);
      end
      out_d       = result;
      zr_d        = (result == '0);
      ng_d        = result[WIDTH-1];
      all1_d      = &result;
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q       <= '0;
      acc_q       <= '0;
      beats_q     <= '0;
      out_valid_q <= 1'b0;
      zr_q        <= 1'b1;
      ng_q        <= 1'b0;
      all1_q      <= 1'b0;
    end else begin
      out_q       <= out_d;
      acc_q       <= acc_d;
      beats_q     <= beats_d;
      out_valid_q <= out_valid_d;
      zr_q        <= zr_d;
      ng_q        <= ng_d;
      all1_q      <= all1_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.zr        = zr_q;
  assign bus.ng        = ng_q;
  assign bus.all1      = all1_q;
  assign bus.beats     = beats_q;

endmodule

// File: tb/tb_logic16_acc.sv
// Directed bench for logic16_acc: plain ops, OR/AND reductions, back-pressure,
// counter saturation (CNT_W=4 instance) and reset in the middle of a reduction.
module tb_logic16_acc;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  logic16_acc_if #(.WIDTH(16), .CNT_W(16)) bus ();
  logic16_acc_if #(.WIDTH(16), .CNT_W(4))  bus4 ();

  logic16_acc #(.WIDTH(16), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic16_acc #(.WIDTH(16), .CNT_W(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic en, input logic clr);
    bus.in_valid = v;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.acc_en   = en;
    bus.acc_clr  = clr;
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 3'b000, 16'h0, 16'h0, 1'b0, 1'b0);
    bus.out_ready   = 1'b1;
    bus4.in_valid   = 1'b0;
    bus4.op         = 3'b001;
    bus4.a          = 16'h0;
    bus4.b          = 16'h0;
    bus4.acc_en     = 1'b0;
    bus4.acc_clr    = 1'b0;
    bus4.out_ready  = 1'b1;

    tick();
    tick();
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_out", {16'b0, bus.out}, 32'h0);
    check("rst_zr", {31'b0, bus.zr}, 32'd1);
    check("rst_ng", {31'b0, bus.ng}, 32'd0);
    check("rst_all1", {31'b0, bus.all1}, 32'd0);
    check("rst_beats", {16'b0, bus.beats}, 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

    // Plain two-operand ops
    drive(1'b1, 3'b001, 16'hAAAA, 16'h5555, 1'b0, 1'b0);
    tick();
    check("or_valid", {31'b0, bus.out_valid}, 32'd1);
    check("or_out", {16'b0, bus.out}, 32'hFFFF);
    check("or_all1", {31'b0, bus.all1}, 32'd1);
    check("or_zr", {31'b0, bus.zr}, 32'd0);
    drive(1'b1, 3'b000, 16'hAAAA, 16'h5555, 1'b0, 1'b0);
    tick();
    check("and_out", {16'b0, bus.out}, 32'h0000);
    check("and_zr", {31'b0, bus.zr}, 32'd1);
    check("and_all1", {31'b0, bus.all1}, 32'd0);
    drive(1'b1, 3'b010, 16'h1234, 16'hABCD, 1'b0, 1'b0);
    tick();
    check("xor_out", {16'b0, bus.out}, 32'hB9F9);
    check("xor_ng", {31'b0, bus.ng}, 32'd1);
    drive(1'b1, 3'b100, 16'h0000, 16'hFFFF, 1'b0, 1'b0);
    tick();
    check("nor_out", {16'b0, bus.out}, 32'h0000);
    drive(1'b1, 3'b011, 16'hFF00, 16'h0FF0, 1'b0, 1'b0);
    tick();
    check("nand_out", {16'b0, bus.out}, 32'hF0FF);
    drive(1'b1, 3'b101, 16'hFF00, 16'h0FF0, 1'b0, 1'b0);
    tick();
    check("xnor_out", {16'b0, bus.out}, 32'h0F0F);
    drive(1'b1, 3'b110, 16'h00FF, 16'h1234, 1'b0, 1'b0);
    tick();
    check("nota_out", {16'b0, bus.out}, 32'hFF00);
    check("nota_ng", {31'b0, bus.ng}, 32'd1);
    drive(1'b1, 3'b111, 16'h0F0F, 16'h1234, 1'b0, 1'b0);
    tick();
    check("passa_out", {16'b0, bus.out}, 32'h0F0F);
    check("plain_beats", {16'b0, bus.beats}, 32'd0);

    // Idle cycle drains the output
    drive(1'b0, 3'b000, 16'h0, 16'h0, 1'b0, 1'b0);
    tick();
    check("drain_valid", {31'b0, bus.out_valid}, 32'd0);
    check("drain_out_hold", {16'b0, bus.out}, 32'h0F0F);

    // OR reduction
    drive(1'b1, 3'b001, 16'h0001, 16'hFFFF, 1'b0, 1'b1);
    tick();
    check("ored_clr", {16'b0, bus.out}, 32'h0001);
    check("ored_beats1", {16'b0, bus.beats}, 32'd1);
    drive(1'b1, 3'b001, 16'h0010, 16'hFFFF, 1'b1, 1'b0);
    tick();
    check("ored_1", {16'b0, bus.out}, 32'h0011);
    drive(1'b1, 3'b001, 16'h0100, 16'hFFFF, 1'b1, 1'b0);
    tick();
    check("ored_2", {16'b0, bus.out}, 32'h0111);
    drive(1'b1, 3'b001, 16'h8000, 16'hFFFF, 1'b1, 1'b0);
    tick();
    check("ored_3", {16'b0, bus.out}, 32'h8111);
    check("ored_beats4", {16'b0, bus.beats}, 32'd4);
    check("ored_ng", {31'b0, bus.ng}, 32'd1);

    // AND reduction
    drive(1'b1, 3'b000, 16'hFFFF, 16'h0000, 1'b1, 1'b1);
    tick();
    check("andred_clr", {16'b0, bus.out}, 32'hFFFF);
    check("andred_beats1", {16'b0, bus.beats}, 32'd1);
    drive(1'b1, 3'b000, 16'hF0F0, 16'h0000, 1'b1, 1'b0);
    tick();
    check("andred_1", {16'b0, bus.out}, 32'hF0F0);
    drive(1'b1, 3'b000, 16'h3CFF, 16'h0000, 1'b1, 1'b0);
    tick();
    check("andred_2", {16'b0, bus.out}, 32'h30F0);
    check("andred_beats3", {16'b0, bus.beats}, 32'd3);

    // Back-pressure: offered beat must stall, nothing advances
    bus.out_ready = 1'b0;
    drive(1'b1, 3'b001, 16'h000F, 16'h0000, 1'b1, 1'b0);
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
      check("bp_out", {16'b0, bus.out}, 32'h30F0);
      check("bp_valid", {31'b0, bus.out_valid}, 32'd1);
      check("bp_beats", {16'b0, bus.beats}, 32'd3);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'b0, bus.in_ready}, 32'd1);
    tick();
    check("bp_release_out", {16'b0, bus.out}, 32'h30FF);
    check("bp_release_beats", {16'b0, bus.beats}, 32'd4);

    // Build beats=3 with a pending output, then reset with a beat offered
    drive(1'b1, 3'b001, 16'h0001, 16'h0000, 1'b0, 1'b1);
    tick();
    drive(1'b1, 3'b001, 16'h0002, 16'h0000, 1'b1, 1'b0);
    tick();
    drive(1'b1, 3'b001, 16'h0004, 16'h0000, 1'b1, 1'b0);
    tick();
    check("pre_rst_out", {16'b0, bus.out}, 32'h0007);
    check("pre_rst_beats", {16'b0, bus.beats}, 32'd3);
    reset = 1'b1;
    drive(1'b1, 3'b001, 16'h00F0, 16'h0000, 1'b1, 1'b0);
    tick();
    check("midrst_valid", {31'b0, bus.out_valid}, 32'd0);
    check("midrst_out", {16'b0, bus.out}, 32'h0000);
    check("midrst_zr", {31'b0, bus.zr}, 32'd1);
    check("midrst_beats", {16'b0, bus.beats}, 32'd0);
    reset = 1'b0;
    drive(1'b1, 3'b001, 16'h0001, 16'h0000, 1'b1, 1'b0);
    tick();
    check("midrst_acc_cleared", {16'b0, bus.out}, 32'h0001);
    check("midrst_beats_after", {16'b0, bus.beats}, 32'd1);
    drive(1'b0, 3'b000, 16'h0, 16'h0, 1'b0, 1'b0);

    // Saturation on the CNT_W=4 instance
    bus4.in_valid = 1'b1;
    bus4.acc_clr  = 1'b1;
    bus4.a        = 16'h0001;
    tick();
    check("sat_clr_beats", {28'b0, bus4.beats}, 32'd1);
    bus4.acc_clr = 1'b0;
    bus4.acc_en  = 1'b1;
    bus4.a       = 16'h0000;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check("sat_beats", {28'b0, bus4.beats}, (i + 1 > 15) ? 32'd15 : 32'(i + 1));
    end
    check("sat_out", {16'b0, bus4.out}, 32'h0001);
    bus4.in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
